// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate strobe, x/y counters, zero-skew syncs.
// Optional frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int TICK_DIV  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [4:0] DIV_LAST   = 5'(TICK_DIV - 1);

  logic [4:0] div_r;
  logic [9:0] next_x_s;
  logic [9:0] next_y_s;
  logic       frame_wrap_s;

  // Next raster position; syncs are decoded from it so they move with the counters.
  always_comb begin
    next_x_s     = pix_x;
    next_y_s     = pix_y;
    frame_wrap_s = 1'b0;
    if (pixel_tick) begin
      if (pix_x == H_LAST) begin
        next_x_s = 10'd0;
        if (pix_y == V_LAST) begin
          next_y_s     = 10'd0;
          frame_wrap_s = 1'b1;
        end else begin
          next_y_s = pix_y + 10'd1;
        end
      end else begin
        next_x_s = pix_x + 10'd1;
      end
    end else begin
      next_x_s = pix_x;
    end
  end

  // Divider, pixel strobe, counters and registered sync/frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r       <= 5'd0;
      pixel_tick  <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (div_r == DIV_LAST) begin
        div_r <= 5'd0;
      end else begin
        div_r <= div_r + 5'd1;
      end
      pixel_tick  <= (div_r == DIV_LAST);
      pix_x       <= next_x_s;
      pix_y       <= next_y_s;
      hsync       <= !((next_x_s >= HS_FIRST) && (next_x_s <= HS_LAST));
      vsync       <= !((next_y_s >= VS_FIRST) && (next_y_s <= VS_LAST));
      frame_start <= frame_wrap_s;
    end
  end

  assign video_on = (pix_x < H_VIS) && (pix_y < V_VIS);

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt_r;

  // Frame counter advances on the cycle carrying the frame_start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_start) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen on a shrunken raster, compared against a
// closed-form timing model driven by the number of clocks since reset release.
module tb_vga_sync_gen;

  localparam int TD  = 3;
  localparam int HD  = 4;
  localparam int HFP = 1;
  localparam int HS  = 2;
  localparam int HBP = 1;
  localparam int VD  = 3;
  localparam int VFP = 1;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int HT  = HD + HFP + HS + HBP;
  localparam int VT  = VD + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;

  logic [32:0] obs;
  logic [32:0] reset_vec;
  logic [32:0] exp_v;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_DISPLAY(VD), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick),
    .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  assign obs = {pixel_tick, pix_x, pix_y, hsync, vsync, video_on, frame_start, frame_cnt};

  // Expected outputs after the k-th clock edge following release.
  function automatic logic [32:0] model(input int kk);
    int p, x, y;
    logic tick, hs_n, vs_n, vo, fs;
    logic [7:0] fc;
    p    = (kk >= 1) ? (kk - 1) / TD : 0;
    x    = p % HT;
    y    = (p / HT) % VT;
    tick = (kk > 0) && (kk % TD == 0);
    hs_n = !((x >= HD + HFP) && (x < HD + HFP + HS));
    vs_n = !((y >= VD + VFP) && (y < VD + VFP + VS));
    vo   = (x < HD) && (y < VD);
    fs   = (kk >= 1) && ((kk - 1) % TD == 0) && (p > 0) && (p % FT == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
    fc   = (kk >= 2) ? 8'((((kk - 2) / TD) / FT) % 256) : 8'd0;
`else
    fc   = 8'd0;
`endif
    return {tick, 10'(x), 10'(y), hs_n, vs_n, vo, fs, fc};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_vec = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    n_checks++;
    if (obs !== reset_vec) begin
      n_fail++;
      $display("FAIL reset_state got %h expected %h", obs, reset_vec);
    end
  endtask

  task automatic test_first_ticks();
    rst_n = 1'b1;
    for (int i = 1; i <= 4 * TD + 2; i++) begin
      @(negedge clk);
      exp_v = model(k);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL first_ticks clk=%0d got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_line();
    int hs_low = 0;
    for (int i = 0; i < TD * HT; i++) begin
      @(negedge clk);
      exp_v = model(k);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL line clk=%0d got %h expected %h", k, obs, exp_v);
      end
      if (pixel_tick && !hsync) hs_low++;
    end
    n_checks++;
    if (hs_low !== HS) begin
      n_fail++;
      $display("FAIL hsync_width got %0d ticks expected %0d", hs_low, HS);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0;
    int fs_cnt = 0;
    for (int i = 0; i < TD * FT; i++) begin
      @(negedge clk);
      exp_v = model(k);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL frame clk=%0d got %h expected %h", k, obs, exp_v);
      end
      if (pixel_tick && !vsync) vs_low++;
      if (frame_start) fs_cnt++;
    end
    n_checks++;
    if (vs_low !== VS * HT) begin
      n_fail++;
      $display("FAIL vsync_width got %0d ticks expected %0d", vs_low, VS * HT);
    end
    n_checks++;
    if (fs_cnt !== 1) begin
      n_fail++;
      $display("FAIL frame_start_count got %0d expected 1", fs_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int run_len;
    for (int r = 0; r < 4; r++) begin
      run_len = $urandom_range(TD * FT * 2, 5);
      repeat (run_len) begin
        @(negedge clk);
        exp_v = model(k);
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL pre_reset clk=%0d got %h expected %h", k, obs, exp_v);
        end
      end
      #($urandom_range(7, 1));
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs !== reset_vec) begin
        n_fail++;
        $display("FAIL async_reset got %h expected %h", obs, reset_vec);
      end
      repeat ($urandom_range(3, 1)) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < TD * FT + 4; i++) begin
        @(negedge clk);
        exp_v = model(k);
        n_checks++;
        if (obs !== exp_v) begin
          n_fail++;
          $display("FAIL restart clk=%0d got %h expected %h", k, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_frame_cnt();
    int frames;
`ifdef VGA_SYNC_FRAME_CNT_EN
    frames = 257;
`else
    frames = 3;
`endif
    for (int i = 0; i < frames * TD * FT; i++) begin
      @(negedge clk);
      exp_v = model(k);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL frame_cnt_run clk=%0d got %h expected %h", k, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_line();
    test_frame();
    test_reset_mid();
    test_frame_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640; visible pixels per line.
REQ-002 Parameter H_FP, default 16; horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96; horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48; horizontal back porch, in pixels.
REQ-005 Parameter V_DISPLAY, default 480; visible lines per frame.
REQ-006 Parameter V_FP, default 10; vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2; vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33; vertical back porch, in lines.
REQ-009 Parameter TICK_DIV, default 2; clk cycles per pixel, legal range 2..16.
REQ-010 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-011 rst_n  input  1  asynchronous, active-low reset.
REQ-012 pixel_tick  output  1  one-clk strobe, once per pixel period.
REQ-013 pix_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-014 pix_y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync, active low.
REQ-016 vsync  output  1  vertical sync, active low.
REQ-017 video_on  output  1  high while the pixel is in the visible area.
REQ-018 frame_start  output  1  one-clk strobe marking the first pixel of a frame.
REQ-019 frame_cnt  output  8  frame counter.

Function
REQ-020 H_TOTAL SHALL equal H_DISPLAY+H_FP+H_SYNC+H_BP (800 at defaults); V_TOTAL SHALL equal V_DISPLAY+V_FP+V_SYNC+V_BP (525 at defaults).
REQ-021 A divider counter SHALL count 0..TICK_DIV-1 and wrap; pixel_tick SHALL be registered and high for exactly one clk when the divider equals TICK_DIV-1.
REQ-022 pix_x SHALL increment on each clk with pixel_tick high; on pix_x==H_TOTAL-1 it SHALL wrap to 0 and pix_y SHALL increment.
REQ-023 On pix_x==H_TOTAL-1 with pix_y==V_TOTAL-1, both counters SHALL wrap to 0 in the same cycle.
REQ-024 pix_x and pix_y SHALL NOT change in cycles where pixel_tick is low.
REQ-025 hsync SHALL be registered and low iff pix_x is in H_DISPLAY+H_FP .. H_DISPLAY+H_FP+H_SYNC-1 (656..751); it SHALL update in the same clk as pix_x, with zero skew.
REQ-026 vsync SHALL be registered and low iff pix_y is in V_DISPLAY+V_FP .. V_DISPLAY+V_FP+V_SYNC-1 (490..491), with the same alignment rule.
REQ-027 video_on SHALL be combinational and equal (pix_x<H_DISPLAY)&&(pix_y<V_DISPLAY).
REQ-028 frame_start SHALL pulse high for one clk, in the clk in which pix_x and pix_y become 0,0 through a wrap.
REQ-029 Downstream painters SHALL sample pix_x and pix_y when pixel_tick is high; each counter value SHALL be stable for TICK_DIV clks.

Reset
REQ-030 While rst_n is low, all registers SHALL clear asynchronously: divider 0, pixel_tick 0, pix_x 0, pix_y 0, hsync 1, vsync 1, frame_start 0, frame_cnt 0.
REQ-031 video_on SHALL read 1 during reset, following REQ-027.
REQ-032 Deassertion of rst_n mid-frame SHALL restart timing at 0,0; the first pixel_tick SHALL occur TICK_DIV clks after release.
REQ-033 The reset release itself SHALL NOT produce a frame_start pulse.

Configuration
REQ-034 With VGA_SYNC_FRAME_CNT_EN defined, frame_cnt SHALL increment modulo 256 in each cycle in which frame_start is high.
REQ-035 Without VGA_SYNC_FRAME_CNT_EN, the frame_cnt port SHALL exist and be tied to 0, and no counter register SHALL be synthesized.

Verification
REQ-036 Reset release, defaults -> pixel_tick high on clk 2, 4, 6, ...; pix_x reads 1 after the first tick; hsync and vsync read 1.
REQ-037 Run one line -> hsync low for exactly 96 ticks, from pix_x=656 through 751; pix_x wraps 799->0 and pix_y steps 0->1 in the same clk.
REQ-038 Run one full frame -> vsync low for 2 lines at pix_y 490..491; after 420000 ticks pix_x,pix_y return to 0,0 with a single frame_start pulse.
REQ-039 Reset asserted at pix_x=300, pix_y=200 -> outputs clear immediately; after release timing restarts from 0,0 with no frame_start.
REQ-040 With VGA_SYNC_FRAME_CNT_EN defined, run 257 frames -> frame_cnt reads 255 then 0 then 1; without the macro, frame_cnt stays 0.
REQ-041 video_on check -> 1 at pix_x=639, pix_y=479; 0 at pix_x=640 and at pix_y=480.
